// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_pkg
//  Description : Shared definitions for the video timing generator: the
//                timing-mode index type, default per-mode timing constants
//                and a helper that sums the four segments of one axis.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  typedef enum logic {
    MODE_0 = 1'b0,
    MODE_1 = 1'b1
  } vt_mode_e;

  // Mode 0 defaults: 640x480, negative syncs
  localparam int C_M0_H_ACT  = 640;
  localparam int C_M0_H_FP   = 16;
  localparam int C_M0_H_SYNC = 96;
  localparam int C_M0_H_BP   = 48;
  localparam int C_M0_V_ACT  = 480;
  localparam int C_M0_V_FP   = 10;
  localparam int C_M0_V_SYNC = 2;
  localparam int C_M0_V_BP   = 33;
  localparam int C_M0_HS_POL = 0;
  localparam int C_M0_VS_POL = 0;

  // Mode 1 defaults: 800x600, positive syncs
  localparam int C_M1_H_ACT  = 800;
  localparam int C_M1_H_FP   = 40;
  localparam int C_M1_H_SYNC = 128;
  localparam int C_M1_H_BP   = 88;
  localparam int C_M1_V_ACT  = 600;
  localparam int C_M1_V_FP   = 1;
  localparam int C_M1_V_SYNC = 4;
  localparam int C_M1_V_BP   = 23;
  localparam int C_M1_HS_POL = 1;
  localparam int C_M1_VS_POL = 1;

  localparam int C_CNT_W = 11;

  // Total length of one axis (pixels per line or lines per frame)
  function automatic int vt_total(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : video_axis_counter
//  Description : Single-axis wrapping counter with sync/active region flags.
//                The segment boundaries arrive as run-time inputs so the
//                parent can switch between timing modes.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                i_en           - advance the counter this cycle
//                i_last         - final count before wrapping to 0
//                i_sync_end     - first count after the sync region
//                i_act_start    - first active count
//                i_act_end      - first count after the active region
//                o_cnt          - current count
//                o_last         - count equals i_last
//                o_sync, o_act  - count lies in sync / active region
//  Revision    : 1.0 - initial release
// ============================================================================
module video_axis_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  input  logic [CNT_W-1:0] i_sync_end,
  input  logic [CNT_W-1:0] i_act_start,
  input  logic [CNT_W-1:0] i_act_end,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_sync,
  output logic             o_act
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  // Equality wrap keeps the counter inside [0, i_last] whatever CNT_W is
  assign w_last = (r_cnt == i_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;
  assign o_sync = (r_cnt < i_sync_end);
  assign o_act  = (r_cnt >= i_act_start) && (r_cnt < i_act_end);

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Two-mode raster timing generator. Line/frame layout is
//                sync, back porch, active, front porch on both axes. The
//                requested mode is captured on the last pixel of a frame and
//                applies from the next (0,0). All outputs are registered one
//                cycle after the counter state.
//  Ports       : vga_clk      - pixel clock
//                reset_n      - async active-low reset
//                mode_sel     - requested timing mode
//                HS, VS       - syncs, asserted level per active mode
//                blank_n      - high in the active picture
//                pix_x, pix_y - active-area coordinates, 0 when blanked
//                line_start   - pulse at h=0
//                frame_start  - pulse at h=0, v=0
//                cur_mode     - mode in effect for the current output
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int M0_H_ACT  = C_M0_H_ACT,
  parameter int M0_H_FP   = C_M0_H_FP,
  parameter int M0_H_SYNC = C_M0_H_SYNC,
  parameter int M0_H_BP   = C_M0_H_BP,
  parameter int M0_V_ACT  = C_M0_V_ACT,
  parameter int M0_V_FP   = C_M0_V_FP,
  parameter int M0_V_SYNC = C_M0_V_SYNC,
  parameter int M0_V_BP   = C_M0_V_BP,
  parameter int M1_H_ACT  = C_M1_H_ACT,
  parameter int M1_H_FP   = C_M1_H_FP,
  parameter int M1_H_SYNC = C_M1_H_SYNC,
  parameter int M1_H_BP   = C_M1_H_BP,
  parameter int M1_V_ACT  = C_M1_V_ACT,
  parameter int M1_V_FP   = C_M1_V_FP,
  parameter int M1_V_SYNC = C_M1_V_SYNC,
  parameter int M1_V_BP   = C_M1_V_BP,
  parameter int M0_HS_POL = C_M0_HS_POL,
  parameter int M0_VS_POL = C_M0_VS_POL,
  parameter int M1_HS_POL = C_M1_HS_POL,
  parameter int M1_VS_POL = C_M1_VS_POL,
  parameter int CNT_W     = C_CNT_W
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             mode_sel,
  output logic             HS,
  output logic             VS,
  output logic             blank_n,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             cur_mode
);

  // Segment boundaries per mode, as counter values
  localparam logic [CNT_W-1:0] C_M0_H_LAST  = CNT_W'(vt_total(M0_H_SYNC, M0_H_BP, M0_H_ACT, M0_H_FP) - 1);
  localparam logic [CNT_W-1:0] C_M0_H_SEND  = CNT_W'(M0_H_SYNC);
  localparam logic [CNT_W-1:0] C_M0_H_ASTA  = CNT_W'(M0_H_SYNC + M0_H_BP);
  localparam logic [CNT_W-1:0] C_M0_H_AEND  = CNT_W'(M0_H_SYNC + M0_H_BP + M0_H_ACT);
  localparam logic [CNT_W-1:0] C_M0_V_LAST  = CNT_W'(vt_total(M0_V_SYNC, M0_V_BP, M0_V_ACT, M0_V_FP) - 1);
  localparam logic [CNT_W-1:0] C_M0_V_SEND  = CNT_W'(M0_V_SYNC);
  localparam logic [CNT_W-1:0] C_M0_V_ASTA  = CNT_W'(M0_V_SYNC + M0_V_BP);
  localparam logic [CNT_W-1:0] C_M0_V_AEND  = CNT_W'(M0_V_SYNC + M0_V_BP + M0_V_ACT);
  localparam logic [CNT_W-1:0] C_M1_H_LAST  = CNT_W'(vt_total(M1_H_SYNC, M1_H_BP, M1_H_ACT, M1_H_FP) - 1);
  localparam logic [CNT_W-1:0] C_M1_H_SEND  = CNT_W'(M1_H_SYNC);
  localparam logic [CNT_W-1:0] C_M1_H_ASTA  = CNT_W'(M1_H_SYNC + M1_H_BP);
  localparam logic [CNT_W-1:0] C_M1_H_AEND  = CNT_W'(M1_H_SYNC + M1_H_BP + M1_H_ACT);
  localparam logic [CNT_W-1:0] C_M1_V_LAST  = CNT_W'(vt_total(M1_V_SYNC, M1_V_BP, M1_V_ACT, M1_V_FP) - 1);
  localparam logic [CNT_W-1:0] C_M1_V_SEND  = CNT_W'(M1_V_SYNC);
  localparam logic [CNT_W-1:0] C_M1_V_ASTA  = CNT_W'(M1_V_SYNC + M1_V_BP);
  localparam logic [CNT_W-1:0] C_M1_V_AEND  = CNT_W'(M1_V_SYNC + M1_V_BP + M1_V_ACT);

  localparam logic C_M0_HS = (M0_HS_POL != 0);
  localparam logic C_M0_VS = (M0_VS_POL != 0);
  localparam logic C_M1_HS = (M1_HS_POL != 0);
  localparam logic C_M1_VS = (M1_VS_POL != 0);

  vt_mode_e         r_mode;
  logic             w_m1;
  logic [CNT_W-1:0] w_h_last, w_h_send, w_h_asta, w_h_aend;
  logic [CNT_W-1:0] w_v_last, w_v_send, w_v_asta, w_v_aend;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_h_wrap, w_h_sync, w_h_act;
  logic             w_v_wrap, w_v_sync, w_v_act;
  logic             w_hs_pol, w_vs_pol, w_active;

  assign w_m1     = (r_mode == MODE_1);
  assign w_h_last = w_m1 ? C_M1_H_LAST : C_M0_H_LAST;
  assign w_h_send = w_m1 ? C_M1_H_SEND : C_M0_H_SEND;
  assign w_h_asta = w_m1 ? C_M1_H_ASTA : C_M0_H_ASTA;
  assign w_h_aend = w_m1 ? C_M1_H_AEND : C_M0_H_AEND;
  assign w_v_last = w_m1 ? C_M1_V_LAST : C_M0_V_LAST;
  assign w_v_send = w_m1 ? C_M1_V_SEND : C_M0_V_SEND;
  assign w_v_asta = w_m1 ? C_M1_V_ASTA : C_M0_V_ASTA;
  assign w_v_aend = w_m1 ? C_M1_V_AEND : C_M0_V_AEND;
  assign w_hs_pol = w_m1 ? C_M1_HS : C_M0_HS;
  assign w_vs_pol = w_m1 ? C_M1_VS : C_M0_VS;

  video_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
    .clk         (vga_clk),
    .rst_n       (reset_n),
    .i_en        (1'b1),
    .i_last      (w_h_last),
    .i_sync_end  (w_h_send),
    .i_act_start (w_h_asta),
    .i_act_end   (w_h_aend),
    .o_cnt       (w_h_cnt),
    .o_last      (w_h_wrap),
    .o_sync      (w_h_sync),
    .o_act       (w_h_act)
  );

  video_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
    .clk         (vga_clk),
    .rst_n       (reset_n),
    .i_en        (w_h_wrap),
    .i_last      (w_v_last),
    .i_sync_end  (w_v_send),
    .i_act_start (w_v_asta),
    .i_act_end   (w_v_aend),
    .o_cnt       (w_v_cnt),
    .o_last      (w_v_wrap),
    .o_sync      (w_v_sync),
    .o_act       (w_v_act)
  );

  assign w_active = w_h_act & w_v_act;

  // The mode register changes on the same edge the counters wrap to (0,0),
  // so the new frame is laid out entirely with the new mode's limits.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= MODE_0;
    end else if (w_h_wrap && w_v_wrap) begin
      r_mode <= vt_mode_e'(mode_sel);
    end
  end

  // Output stage: everything derived from the same counter state, one cycle later
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      HS          <= ~C_M0_HS;
      VS          <= ~C_M0_VS;
      blank_n     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cur_mode    <= 1'b0;
    end else begin
      HS          <= w_h_sync ? w_hs_pol : ~w_hs_pol;
      VS          <= w_v_sync ? w_vs_pol : ~w_vs_pol;
      blank_n     <= w_active;
      pix_x       <= w_active ? (w_h_cnt - w_h_asta) : '0;
      pix_y       <= w_active ? (w_v_cnt - w_v_asta) : '0;
      line_start  <= (w_h_cnt == '0);
      frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
      cur_mode    <= w_m1;
    end
  end

endmodule
`default_nettype wire
